// File: rtl/cpu_control_sequencer_pkg.sv
// Shared types for the CPU control sequencer: opcode map, T-state encoding
// and the control word that fans out to the datapath enables.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
    logic instr_done;
    logic halted;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NONE = '0;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Sequencer-to-datapath bundle: IR/flags inputs plus every register enable.
interface cpu_control_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic       flag_z;
  logic       pc_inc, pc_out, pc_load;
  logic       mar_load;
  logic       ram_out, ram_load;
  logic       ir_load, ir_out;
  logic       a_load, a_out, b_load;
  logic       alu_out, alu_sub, flags_load;
  logic       out_load;
  logic       instr_done;
  logic       halted;

  modport master (
    input  run, opcode, flag_z,
    output pc_inc, pc_out, pc_load, mar_load, ram_out, ram_load,
           ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
           flags_load, out_load, instr_done, halted
  );

  modport slave (
    output run, opcode, flag_z,
    input  pc_inc, pc_out, pc_load, mar_load, ram_out, ram_load,
           ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub,
           flags_load, out_load, instr_done, halted
  );
endinterface

// File: rtl/cpu_control_sequencer_decode.sv
// Combinational T-state decode: (state, opcode, flag_z) -> control word,
// last-step flag and next state.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_flag_z,
  output ctrl_word_t o_ctrl,
  output logic       o_last_step,
  output state_t     o_next_state
);

  always_comb begin
    o_ctrl       = CTRL_NONE;
    o_next_state = i_state;
    case (i_state)
      ST_IDLE: o_next_state = ST_T0;
      ST_T0: begin
        o_ctrl.pc_out   = 1'b1;
        o_ctrl.mar_load = 1'b1;
        o_next_state    = ST_T1;
      end
      ST_T1: begin
        o_ctrl.ram_out = 1'b1;
        o_ctrl.ir_load = 1'b1;
        o_ctrl.pc_inc  = 1'b1;
        o_next_state   = ST_T2;
      end
      ST_T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrl.ir_out   = 1'b1;
            o_ctrl.mar_load = 1'b1;
            o_next_state    = ST_T3;
          end
          OP_LDI: begin
            o_ctrl.ir_out     = 1'b1;
            o_ctrl.a_load     = 1'b1;
            o_ctrl.instr_done = 1'b1;
          end
          OP_JMP: begin
            o_ctrl.ir_out     = 1'b1;
            o_ctrl.pc_load    = 1'b1;
            o_ctrl.instr_done = 1'b1;
          end
          OP_JZ: begin
            o_ctrl.ir_out     = i_flag_z;
            o_ctrl.pc_load    = i_flag_z;
            o_ctrl.instr_done = 1'b1;
          end
          OP_OUT: begin
            o_ctrl.a_out      = 1'b1;
            o_ctrl.out_load   = 1'b1;
            o_ctrl.instr_done = 1'b1;
          end
          OP_HLT: begin
            o_ctrl.instr_done = 1'b1;
            o_next_state      = ST_HALT;
          end
          default: o_ctrl.instr_done = 1'b1;
        endcase
      end
      ST_T3: begin
        case (i_opcode)
          OP_LDA: begin
            o_ctrl.ram_out    = 1'b1;
            o_ctrl.a_load     = 1'b1;
            o_ctrl.instr_done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_ctrl.ram_out = 1'b1;
            o_ctrl.b_load  = 1'b1;
            o_next_state   = ST_T4;
          end
          OP_STA: begin
            o_ctrl.a_out      = 1'b1;
            o_ctrl.ram_load   = 1'b1;
            o_ctrl.instr_done = 1'b1;
          end
          default: o_ctrl.instr_done = 1'b1;
        endcase
      end
      ST_T4: begin
        o_ctrl.alu_out    = 1'b1;
        o_ctrl.a_load     = 1'b1;
        o_ctrl.flags_load = 1'b1;
        o_ctrl.alu_sub    = (i_opcode == OP_SUB);
        o_ctrl.instr_done = 1'b1;
      end
      ST_HALT: o_ctrl.halted = 1'b1;
      default: o_next_state = ST_IDLE;
    endcase

    // Every completing step except HLT returns to the fetch.
    o_last_step = o_ctrl.instr_done;
    if (o_last_step && (o_next_state != ST_HALT)) o_next_state = ST_T0;
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// T-state sequencer top: state register plus run gating of the decoded word.
// state | meaning
// IDLE  | after reset, waits for run
// T0/T1 | fetch: PC->MAR, RAM->IR with PC increment
// T2-T4 | opcode-dependent execute steps
// HALT  | sticky until rst_
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     rst_,
  cpu_control_sequencer_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  ctrl_word_t w_ctrl;
  ctrl_word_t w_out;
  logic       w_last;

  cpu_ctrl_decode u_decode (
    .i_state      (r_state),
    .i_opcode     (bus.opcode),
    .i_flag_z     (bus.flag_z),
    .o_ctrl       (w_ctrl),
    .o_last_step  (w_last),
    .o_next_state (w_next)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                                r_state <= ST_IDLE;
    else if (bus.run && r_state != ST_HALT)   r_state <= w_next;
  end

  // halted reflects HALT regardless of run; everything else freezes to 0.
  always_comb begin
    w_out        = bus.run ? w_ctrl : CTRL_NONE;
    w_out.halted = w_ctrl.halted;
  end

  assign bus.pc_inc     = w_out.pc_inc;
  assign bus.pc_out     = w_out.pc_out;
  assign bus.pc_load    = w_out.pc_load;
  assign bus.mar_load   = w_out.mar_load;
  assign bus.ram_out    = w_out.ram_out;
  assign bus.ram_load   = w_out.ram_load;
  assign bus.ir_load    = w_out.ir_load;
  assign bus.ir_out     = w_out.ir_out;
  assign bus.a_load     = w_out.a_load;
  assign bus.a_out      = w_out.a_out;
  assign bus.b_load     = w_out.b_load;
  assign bus.alu_out    = w_out.alu_out;
  assign bus.alu_sub    = w_out.alu_sub;
  assign bus.flags_load = w_out.flags_load;
  assign bus.out_load   = w_out.out_load;
  assign bus.instr_done = w_out.instr_done;
  assign bus.halted     = w_out.halted;

  always @(posedge clk) begin
    if (rst_) begin
      assert ($countones({w_out.pc_out, w_out.ram_out, w_out.ir_out,
                          w_out.a_out, w_out.alu_out}) <= 1);
      assert (!w_last || w_next == ST_T0 || w_next == ST_HALT);
    end
  end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Sequencer for the 8-bit basic CPU, placed between the instruction register and every 8-bit enable-register in the datapath. It consumes the opcode nibble from the instruction register's output and drives the load/output enables of PC, MAR, RAM, IR, A, B, flags and output registers. It runs a variable-length T-state machine: two fetch steps, then one to three execute steps per opcode.

## Interface
Parameters:
- none (the opcode map and the state encoding are fixed in the package)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_  in  1  reset, asynchronous, active-low
- run  in  1  1 = sequencer advances; 0 = freeze state, all control outputs forced 0
- opcode  in  4  instruction register out[7:4]
- flag_z  in  1  zero flag from the flags register
- pc_inc, pc_out, pc_load  out  1 each  program counter increment / bus drive / load
- mar_load  out  1  memory address register load enable
- ram_out, ram_load  out  1 each  RAM read-to-bus / write-from-bus
- ir_load, ir_out  out  1 each  IR load; IR low nibble drives the bus
- a_load, a_out, b_load  out  1 each  A register load / bus drive, B register load
- alu_out, alu_sub, flags_load  out  1 each  ALU result to bus, subtract select, flags capture
- out_load  out  1  output register load enable
- instr_done  out  1  high during the final step of every instruction
- halted  out  1  high while in HALT

## Operation
- States: IDLE, T0, T1, T2, T3, T4, HALT.
- Control outputs are a combinational decode of (state, opcode, flag_z), ANDed with run. Outside the listed steps every output is 0.
- IDLE: all outputs 0. Goes to T0 on the first edge with run=1.
- Fetch:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- Execute steps. The opcode is valid from T2 on. Each entry is "opcode name: steps"; "→T0" means the last listed step asserts instr_done and the next state is T0.
  - 0x0 NOP, and every undefined opcode (0x7, 0x9–0xD): T2 instr_done only →T0.
  - 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load →T0.
  - 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load →T0.
  - 0x3 SUB: same as ADD, plus alu_sub in T4.
  - 0x4 STA: T2 ir_out+mar_load; T3 a_out+ram_load →T0.
  - 0x5 LDI: T2 ir_out+a_load →T0.
  - 0x6 JMP: T2 ir_out+pc_load →T0.
  - 0x8 JZ: T2 ir_out+pc_load only if flag_z=1; instr_done in either case →T0.
  - 0xE OUT: T2 a_out+out_load →T0.
  - 0xF HLT: T2 instr_done; next state HALT.
- HALT: halted=1, all other outputs 0. Sticky; only rst_ leaves it.
- Bus exclusivity: at most one of pc_out, ram_out, ir_out, a_out, alu_out is 1 in any cycle. This is an invariant.

## Timing
- Reset (rst_=0): state=IDLE immediately and asynchronously; all outputs 0, including halted and instr_done.
- Reset mid-instruction: abort with no completion. The first fetch after release starts at T0.
- run=0: state holds, outputs 0 in the same cycle. On run=1 the sequencer resumes the held step with its full control word.
- run is ignored in HALT.
- Instruction length, fetch included:
  - 3 cycles: NOP, LDI, JMP, JZ, OUT, HLT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.
- A downstream register captures on the rising edge that ends the step asserting its enable.
- opcode and flag_z are sampled combinationally in T2–T4. They must be stable from the edge ending T1.

## Structure
- Package cpu_ctrl_pkg holds:
  - typedef enum logic [3:0] opcode_t (the values above);
  - typedef enum for the state, encoded 3-bit binary;
  - packed struct ctrl_word_t with one bit per control output;
  - constant CTRL_NONE (all zeros).
- Sub-module cpu_ctrl_decode is a purely combinational decode from (state, opcode, flag_z) to {ctrl_word_t, last_step, next_state}.
- The top holds the state register and the run gating.

## Test plan
- Reset then run=1, opcode=0x5:
  - IDLE→T0→T1→T2→T0;
  - pc_out+mar_load in T0, ram_out+ir_load+pc_inc in T1, ir_out+a_load+instr_done in T2.
- opcode=0x2, run=1:
  - T4 asserts alu_out, a_load, flags_load with alu_sub=0;
  - instr_done only in T4; next state T0.
  - Repeat with opcode=0x3: alu_sub=1 only in T4.
- opcode=0x8:
  - flag_z=0: T2 has pc_load=0, instr_done=1.
  - flag_z=1: T2 has pc_load=1 and ir_out=1.
- run deasserted in T3 of LDA for 4 cycles:
  - outputs all 0 and state holds for those cycles;
  - on resume, ram_out+a_load are asserted, then T0.
- opcode=0xF:
  - halted=1 from the cycle after T2 and stays 1 for 10 cycles with run toggling;
  - rst_ pulse clears it, state IDLE.
- Random opcodes for 1000 instructions: assertion that at most one bus driver is 1 per cycle, plus cycle-count checks per opcode.
